// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: N input channels, one registered output.
// master drives the channels and out_ready; slave is the mux itself.
interface mux_rr_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_ready;

  modport master (
    output mode,
    output sel,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  mode,
    input  sel,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

endinterface

// File: rtl/mux_rr_reg.sv
// N-channel registered mux, external select or round-robin arbitration.
// One output register: one-cycle latency, full throughput.
module mux_rr_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  mux_rr_reg_if.slave bus
);

  localparam logic [SEL_W:0]   N_W  = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);

  logic                 load;
  logic                 grant;
  logic [SEL_W-1:0]     chan;
  logic                 sel_grant;
  logic                 rr_grant;
  logic [SEL_W-1:0]     rr_chan;
  logic [SEL_W-1:0]     ptr;
  logic [SEL_W-1:0]     ptr_nxt;
  logic [2*N-1:0]       dbl;
  logic [2*N-1:0]       rot;
  logic [SEL_W:0]       off;
  logic [SEL_W:0]       sum;
  logic [WIDTH-1:0]     data_arr [N];
  logic [WIDTH-1:0]     data_mux;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SEL_W-1:0]     out_sel_q;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_arr[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign load = ~out_valid_q | bus.out_ready;

  // sel values with no matching channel simply never grant
  always_comb begin
    sel_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_grant = bus.in_valid[i];
      end
    end
  end

  // rotate valids so ptr lands on bit 0, then take the lowest set bit
  assign dbl = {bus.in_valid, bus.in_valid};
  assign rot = dbl >> ptr;

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = (SEL_W+1)'(j);
      end
    end
  end

  assign rr_grant = |bus.in_valid;
  assign sum      = {1'b0, ptr} + off;

  always_comb begin
    rr_chan = sum[SEL_W-1:0];
    if (sum >= N_W) begin
      rr_chan = SEL_W'(sum - N_W);
    end
  end

  assign grant = bus.mode ? rr_grant : sel_grant;
  assign chan  = bus.mode ? rr_chan  : bus.sel;

  always_comb begin
    bus.in_ready = '0;
    data_mux     = '0;
    for (int i = 0; i < N; i++) begin
      if (chan == SEL_W'(i)) begin
        bus.in_ready[i] = load & grant;
        data_mux        = data_arr[i];
      end
    end
  end

  assign ptr_nxt = (chan == LAST) ? '0 : chan + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (grant) begin
        out_valid_q <= 1'b1;
        out_data_q  <= data_mux;
        out_sel_q   <= chan;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (bus.mode & load & grant) begin
      ptr <= ptr_nxt;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  a_onehot_ready: assert property (
    @(posedge clk) disable iff (rst) $onehot0(bus.in_ready)
  );

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: N=4 vector table plus
// hand sequences for sparse round-robin and an N=3 instance.
module tb_mux_rr_reg;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux_rr_reg_if #(.WIDTH(32), .N(4), .SEL_W(2)) b4 ();
  mux_rr_reg_if #(.WIDTH(32), .N(3), .SEL_W(2)) b3 ();

  mux_rr_reg #(.WIDTH(32), .N(4), .SEL_W(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  mux_rr_reg #(.WIDTH(32), .N(3), .SEL_W(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        m;
    logic [1:0]  s;
    logic [3:0]  v;
    logic        o;
    logic [3:0]  ir;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t t);
    rst          = t.r;
    b4.mode      = t.m;
    b4.sel       = t.s;
    b4.in_valid  = t.v;
    b4.out_ready = t.o;
    #1;
    chk({tag, " in_ready"}, 32'(b4.in_ready), 32'(t.ir));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(b4.out_valid), 32'(t.ov));
    chk({tag, " out_data"}, b4.out_data, t.od);
    chk({tag, " out_sel"}, 32'(b4.out_sel), 32'(t.os));
  endtask

  task automatic step3(input string tag,
                       input logic m,
                       input logic [1:0] s,
                       input logic [2:0] v,
                       input logic [2:0] ir,
                       input logic ov,
                       input logic [31:0] od,
                       input logic [1:0] os);
    b3.mode      = m;
    b3.sel       = s;
    b3.in_valid  = v;
    b3.out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(b3.in_ready), 32'(ir));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(b3.out_valid), 32'(ov));
    chk({tag, " out_data"}, b3.out_data, od);
    chk({tag, " out_sel"}, 32'(b3.out_sel), 32'(os));
  endtask

  function automatic vec_t rr(input logic o,
                              input logic [3:0] v,
                              input logic [3:0] ir,
                              input logic ov,
                              input logic [31:0] od,
                              input logic [1:0] os);
    vec_t t;
    t = '{1'b0, 1'b1, 2'd0, v, o, ir, ov, od, os};
    return t;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // select mode, then a reset that swallows a live handshake
    tbl[0]  = '{0, 1, 2'd0, 4'hF, 1, 4'b0001, 1, 32'hA0, 2'd0};
    tbl[1]  = '{0, 0, 2'd2, 4'hF, 1, 4'b0100, 1, 32'hA2, 2'd2};
    tbl[2]  = '{0, 0, 2'd0, 4'hF, 1, 4'b0001, 1, 32'hA0, 2'd0};
    tbl[3]  = '{0, 0, 2'd3, 4'hF, 1, 4'b1000, 1, 32'hA3, 2'd3};
    tbl[4]  = '{0, 0, 2'd2, 4'hB, 1, 4'b0000, 0, 32'hA3, 2'd3};
    tbl[5]  = '{1, 1, 2'd0, 4'hF, 1, 4'b0010, 0, 32'h00, 2'd0};
    // round-robin fairness, ptr starts at 0
    tbl[6]  = rr(1, 4'hF, 4'b0001, 1, 32'hA0, 2'd0);
    tbl[7]  = rr(1, 4'hF, 4'b0010, 1, 32'hA1, 2'd1);
    tbl[8]  = rr(1, 4'hF, 4'b0100, 1, 32'hA2, 2'd2);
    tbl[9]  = rr(1, 4'hF, 4'b1000, 1, 32'hA3, 2'd3);
    tbl[10] = rr(1, 4'hF, 4'b0001, 1, 32'hA0, 2'd0);
    tbl[11] = rr(1, 4'hF, 4'b0010, 1, 32'hA1, 2'd1);
    tbl[12] = rr(1, 4'hF, 4'b0100, 1, 32'hA2, 2'd2);
    tbl[13] = rr(1, 4'hF, 4'b1000, 1, 32'hA3, 2'd3);
    // backpressure for three cycles, then same-cycle reload
    tbl[14] = rr(0, 4'hF, 4'b0000, 1, 32'hA3, 2'd3);
    tbl[15] = rr(0, 4'hF, 4'b0000, 1, 32'hA3, 2'd3);
    tbl[16] = rr(0, 4'hF, 4'b0000, 1, 32'hA3, 2'd3);
    tbl[17] = rr(1, 4'hF, 4'b0001, 1, 32'hA0, 2'd0);
    tbl[18] = rr(1, 4'h0, 4'b0000, 0, 32'hA0, 2'd0);
    // stall then reset drops the held word
    tbl[19] = rr(1, 4'hF, 4'b0010, 1, 32'hA1, 2'd1);
    tbl[20] = rr(0, 4'hF, 4'b0000, 1, 32'hA1, 2'd1);
    tbl[21] = '{1, 1, 2'd0, 4'hF, 0, 4'b0000, 0, 32'h00, 2'd0};

    rst          = 1'b1;
    b4.mode      = 1'b1;
    b4.sel       = 2'd0;
    b4.in_valid  = 4'hF;
    b4.out_ready = 1'b1;
    b4.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    b3.mode      = 1'b0;
    b3.sel       = 2'd0;
    b3.in_valid  = 3'b000;
    b3.out_ready = 1'b1;
    b3.in_data   = {32'hB2, 32'hB1, 32'hB0};

    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d out_valid", k), 32'(b4.out_valid), 32'd0);
      chk($sformatf("rst%0d out_data", k), b4.out_data, 32'd0);
      chk($sformatf("rst%0d out_sel", k), 32'(b4.out_sel), 32'd0);
      chk($sformatf("rst%0d n3 valid", k), 32'(b3.out_valid), 32'd0);
    end
    chk("rst in_ready", 32'(b4.in_ready), 32'b0001);

    for (int i = 0; i < 22; i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    // sparse round-robin: walk ptr to 2, then only channels 1 and 3
    step("sp0", rr(1, 4'hF, 4'b0001, 1, 32'hA0, 2'd0));
    step("sp1", rr(1, 4'hF, 4'b0010, 1, 32'hA1, 2'd1));
    step("sp2", rr(1, 4'hA, 4'b1000, 1, 32'hA3, 2'd3));
    step("sp3", rr(1, 4'hA, 4'b0010, 1, 32'hA1, 2'd1));
    step("sp4", rr(1, 4'hA, 4'b1000, 1, 32'hA3, 2'd3));
    // ptr is 0 here; a select-mode grant must leave it untouched
    step("mx0", '{0, 0, 2'd1, 4'hA, 1, 4'b0010, 1, 32'hA1, 2'd1});
    step("mx1", rr(1, 4'hA, 4'b0010, 1, 32'hA1, 2'd1));

    // odd N: sel=3 has no channel behind it
    step3("n3a", 0, 2'd3, 3'b111, 3'b000, 0, 32'h00, 2'd0);
    step3("n3b", 0, 2'd2, 3'b111, 3'b100, 1, 32'hB2, 2'd2);
    step3("n3c", 0, 2'd3, 3'b111, 3'b000, 0, 32'hB2, 2'd2);
    step3("n3d", 1, 2'd0, 3'b111, 3'b001, 1, 32'hB0, 2'd0);
    step3("n3e", 1, 2'd0, 3'b111, 3'b010, 1, 32'hB1, 2'd1);
    step3("n3f", 1, 2'd0, 3'b111, 3'b100, 1, 32'hB2, 2'd2);
    step3("n3g", 1, 2'd0, 3'b111, 3'b001, 1, 32'hB0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
